// File: rtl/i2c_cfg_sequencer_if.sv
// i2c_cfg_sequencer_if: table ROM and I2C master bus seen by the configuration sequencer
interface i2c_cfg_sequencer_if #(
    parameter int ADDR_W = 6
);
    logic [ADDR_W-1:0] oROM_ADDR;
    logic [23:0]       iROM_DATA;
    logic              oI2C_GO;
    logic [23:0]       oI2C_DATA;
    logic              iI2C_END;
    logic              iI2C_ACK;

    modport master (
        output oROM_ADDR, oI2C_GO, oI2C_DATA,
        input  iROM_DATA, iI2C_END, iI2C_ACK
    );

    modport slave (
        input  oROM_ADDR, oI2C_GO, oI2C_DATA,
        output iROM_DATA, iI2C_END, iI2C_ACK
    );
endinterface

// File: rtl/i2c_cfg_sequencer.sv
// i2c_cfg_sequencer: walks the power-up configuration ROM and writes each {dev, reg, data}
// word through the shared I2C master, retrying NACKs/timeouts and flagging hard failures.
// Optional macro CFG_RETRIGGER_EN: iSTART in DONE or ERROR restarts the table from index 0.
module i2c_cfg_sequencer #(
    parameter int LUT_SIZE       = 51,
    parameter int ADDR_W         = 6,
    parameter int MAX_RETRY      = 3,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 iCLK,
    input  logic                 iRST_n,
    input  logic                 iSTART,
    i2c_cfg_sequencer_if.master  bus,
    output logic                 oCFG_BUSY,
    output logic                 oCFG_DONE,
    output logic                 oCFG_ERR,
    output logic [ADDR_W-1:0]    oERR_INDEX
);
    localparam int TMAX = TIMEOUT_CYCLES > GAP_CYCLES ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int RW   = $clog2(MAX_RETRY + 2);

    typedef enum logic [2:0] {IDLE, FETCH, WAIT_ROM, ISSUE, WAIT_END, GAP, DONE, ERROR} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] index_q, index_d, err_idx_q, err_idx_d;
    logic [RW-1:0]     retry_q, retry_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [23:0]       data_q, data_d;
    logic              last, timeout, gap_end;

    assign last    = index_q == ADDR_W'(LUT_SIZE - 1);
    assign timeout = timer_q == TW'(TIMEOUT_CYCLES - 1);
    assign gap_end = timer_q == TW'(GAP_CYCLES - 1);

    assign bus.oROM_ADDR = index_q;
    assign bus.oI2C_GO   = state_q == ISSUE;
    assign bus.oI2C_DATA = data_q;
    assign oCFG_BUSY     = !(state_q inside {IDLE, DONE, ERROR});
    assign oCFG_DONE     = state_q == DONE;
    assign oCFG_ERR      = state_q == ERROR;
    assign oERR_INDEX    = err_idx_q;

    // State and datapath registers; reset aborts any sequence in flight.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q   <= IDLE;
            index_q   <= '0;
            err_idx_q <= '0;
            retry_q   <= '0;
            timer_q   <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            err_idx_q <= err_idx_d;
            retry_q   <= retry_d;
            timer_q   <= timer_d;
            data_q    <= data_d;
        end
    end

    // Next state: one table entry per fetch/issue/wait/gap loop, END outranks a timeout.
    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        err_idx_d = err_idx_q;
        retry_d   = retry_q;
        timer_d   = timer_q;
        data_d    = data_q;
        case (state_q)
            IDLE: if (iSTART) begin
                state_d = FETCH;
                index_d = '0;
                retry_d = '0;
            end
            FETCH:    state_d = WAIT_ROM;
            WAIT_ROM: begin
                data_d  = bus.iROM_DATA;
                state_d = ISSUE;
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT_END;
            end
            WAIT_END: begin
                timer_d = timer_q + 1'b1;
                if (bus.iI2C_END && bus.iI2C_ACK) begin
                    timer_d = '0;
                    retry_d = '0;
                    index_d = last ? index_q : index_q + 1'b1;
                    state_d = last ? DONE : GAP;
                end else if (bus.iI2C_END || timeout) begin
                    timer_d = '0;
                    if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d = retry_q + 1'b1;
                        state_d = GAP;
                    end else begin
                        err_idx_d = index_q;
                        state_d   = ERROR;
                    end
                end
            end
            GAP: begin
                timer_d = gap_end ? '0 : timer_q + 1'b1;
                state_d = gap_end ? FETCH : GAP;
            end
            DONE, ERROR: begin
`ifdef CFG_RETRIGGER_EN
                if (iSTART) begin
                    state_d   = FETCH;
                    index_d   = '0;
                    retry_d   = '0;
                    err_idx_d = '0;
                end
`endif
            end
        endcase
    end
endmodule

// File: doc/i2c_cfg_sequencer.md
Name: i2c_cfg_sequencer

Overview:
Sequences the power-up register configuration of an external I2C device after the power-on delay start pulse fires. Walks a configuration table (synchronous ROM) of {device addr, reg addr, data} words. Issues each word to the shared I2C master via a go/end handshake, retries NACKed writes and flags unrecoverable failures. Sits between the power-on delay counter, the table ROM and the I2C master.

Parameters:
LUT_SIZE, 51, number of table entries (1..2**ADDR_W)
ADDR_W, 6, table address width
MAX_RETRY, 3, retries allowed per entry after the first failed attempt
GAP_CYCLES, 16, idle iCLK cycles between successive I2C transactions (>=1)
TIMEOUT_CYCLES, 65535, cycles allowed for iI2C_END before the attempt counts as failed

Ports:
iCLK  input  1  system clock
iRST_n  input  1  asynchronous active-low reset
iSTART  input  1  single-cycle start pulse from the power-on delay block
oROM_ADDR  output  ADDR_W  table read address
iROM_DATA  input  24  table word {dev[23:16], reg[15:8], data[7:0]}, valid 1 cycle after oROM_ADDR
oI2C_GO  output  1  single-cycle transaction request
oI2C_DATA  output  24  word to transmit, held stable from GO until END
iI2C_END  input  1  single-cycle completion pulse from the I2C master
iI2C_ACK  input  1  1 = all bytes acknowledged; sampled only with iI2C_END
oCFG_BUSY  output  1  sequence in progress
oCFG_DONE  output  1  all entries written successfully (sticky)
oCFG_ERR  output  1  entry failed after retries (sticky)
oERR_INDEX  output  ADDR_W  table index of the failing entry

Behaviour:
- Reset (async, iRST_n low): state IDLE. All outputs 0, index 0, retry count 0, timers 0.
- States: IDLE, FETCH, WAIT_ROM, ISSUE, WAIT_END, GAP, DONE, ERROR.
- IDLE: oCFG_BUSY=0. On iSTART=1: index<=0, retry<=0, go to FETCH.
- FETCH: drive oROM_ADDR=index. Go to WAIT_ROM.
- WAIT_ROM: latch iROM_DATA into oI2C_DATA at the end of this cycle. Go to ISSUE.
- ISSUE: oI2C_GO=1 for exactly this cycle. Clear the timeout counter. Go to WAIT_END.
- WAIT_END: wait for iI2C_END.
  - iI2C_END & iI2C_ACK: success. retry<=0. If index==LUT_SIZE-1, go to DONE; else index+1, go to GAP.
  - iI2C_END & !iI2C_ACK, or timeout counter reaches TIMEOUT_CYCLES-1: failure.
    - retry<MAX_RETRY: retry+1, go to GAP; the same index is re-fetched.
    - Otherwise: oERR_INDEX<=index, go to ERROR.
  - iI2C_END takes priority over a timeout in the same cycle.
- GAP: count GAP_CYCLES cycles, then go to FETCH.
- DONE: oCFG_DONE=1, oCFG_BUSY=0. Stays until reset.
- ERROR: oCFG_ERR=1, oCFG_BUSY=0. Stays until reset.
- oCFG_BUSY=1 in every state except IDLE, DONE and ERROR.
- iSTART is ignored whenever the state is not IDLE.
- A stray iI2C_END outside WAIT_END is ignored.
- Latency from iSTART to the first oI2C_GO is exactly 3 cycles (FETCH, WAIT_ROM, ISSUE).
- oI2C_DATA changes only in WAIT_ROM.
- oCFG_DONE and oCFG_ERR are mutually exclusive.
- Reset mid-sequence aborts immediately; the I2C master is expected to be reset by the same iRST_n.

Optional Feature:
CFG_RETRIGGER_EN
- Defined: iSTART while in DONE or ERROR clears oCFG_DONE, oCFG_ERR and oERR_INDEX, and restarts at index 0 (enters FETCH next cycle).
- Undefined: DONE and ERROR are terminal until reset, and iSTART is ignored there.

Test Plan:
- LUT_SIZE=4, master always ACKs with END 10 cycles after GO, pulse iSTART -> exactly 4 GO pulses, words match ROM[0..3], GO-to-GO spacing = 10+GAP_CYCLES+3, oCFG_DONE=1 after the 4th END, oCFG_ERR=0.
- Entry 2 NACKs once, then ACKs -> entry 2 is issued twice with identical oI2C_DATA, the sequence completes, oCFG_DONE=1.
- Entry 1 always NACKs, MAX_RETRY=3 -> 4 GO pulses for index 1, then oCFG_ERR=1, oERR_INDEX=1, oCFG_BUSY=0, no further GO.
- Master never returns END, TIMEOUT_CYCLES=100, MAX_RETRY=0 -> oCFG_ERR=1 with oERR_INDEX=0, 100 cycles after the first GO.
- iSTART pulsed again mid-sequence, and iRST_n low while in WAIT_END -> the second iSTART has no effect; reset forces all outputs to 0 asynchronously and IDLE.
- With CFG_RETRIGGER_EN: iSTART in DONE -> oCFG_DONE clears and the sequence replays from index 0. Without the macro -> oCFG_DONE stays 1 and no GO is issued.
